oppm_rx_framer: RTL

Parametrised OPPM packet receiver: recovers frame timing from a pulse stream, validates a preamble, and assembles data symbols MSB-first into packets. It also detects framing errors and buffers completed packets in a first-word-fall-through FIFO with a valid/ready handshake. It sits between the optical front-end pulse input and the packet consumer, and succeeds the single-packet decoder. It adds error detection, timing realignment, multi-packet buffering and overflow reporting.

---
 rtl/oppm_rx_framer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/oppm_rx_framer.sv
// OPPM packet receiver: recovers frame timing from the pulse stream, checks the
// preamble, assembles data symbols MSB-first and queues finished packets in a
// first-word-fall-through FIFO.
// Latency: a packet is pushed at the last tick of its final data frame; out_valid
//          rises on the next cycle (F - t_e cycles after the last data edge).
// Backpressure: out_valid/out_ready pop. A packet that completes while the FIFO is
//          full and no pop happens that cycle is dropped and overflow pulses.
// Ports: clk/rst_n (async, active-low); pulse in; out_data/out_valid/out_ready
//        packet stream; err/err_code framing errors; overflow drop strobe;
//        busy (not idle); fifo_count (entries held).
module oppm_rx_framer #(
    parameter int N_MOD  = 2,
    parameter int L      = 8,
    parameter int N_PKT  = 8,
    parameter int PRE_CT = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pulse,
    output logic [N_PKT-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic                       overflow,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int M        = 1 << N_MOD;
    localparam int F        = M * L;
    localparam int DATA_SYM = (N_PKT + N_MOD - 1) / N_MOD;
    localparam int AW       = DATA_SYM * N_MOD;
    localparam int TW       = $clog2(F);
    localparam int PCW      = $clog2(PRE_CT + 1);
    localparam int SCW      = $clog2(DATA_SYM + 1);
    localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW       = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, PREAM, DATA} state_t;

    state_t            state;
    logic              pulse_q;
    logic [TW-1:0]     t;
    logic              seen;
    logic [PCW-1:0]    pre_cnt;
    logic [SCW-1:0]    sym_cnt;
    logic [N_MOD-1:0]  sym;
    logic [AW-1:0]     asm_r;

    logic [N_PKT-1:0]  mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    // ---------------- frame timing and error detection ----------------
    logic             edge_det;
    logic             active;
    logic             t_last;
    logic [N_MOD-1:0] slot;
    logic             e_multi;
    logic             e_pream;
    logic             e_miss;
    logic             any_err;
    logic [1:0]       code;
    logic [N_MOD-1:0] sym_now;
    logic [AW-1:0]    asm_next;
    logic             complete;
    logic             pop;
    logic             push;
    logic             drop;

    assign edge_det = pulse & ~pulse_q;
    assign active   = (state == PREAM) || (state == DATA);
    assign t_last   = (t == TW'(F - 1));
    assign slot     = N_MOD'(t / TW'(L));

    assign e_multi  = active & edge_det & seen;
    assign e_pream  = (state == PREAM) & edge_det & (slot != '0);
    // An edge on the last tick still counts for the frame that is closing.
    assign e_miss   = active & t_last & ~seen & ~edge_det;
    assign any_err  = e_multi | e_pream | e_miss;
    assign code     = e_multi ? 2'b10 : (e_pream ? 2'b11 : 2'b01);

    // Symbol for the closing frame: a same-tick edge has not been latched yet.
    assign sym_now  = (edge_det && !seen) ? slot : sym;
    assign asm_next = (asm_r << N_MOD) | AW'(sym_now);
    assign complete = (state == DATA) & t_last & ~any_err &
                      (sym_cnt == SCW'(DATA_SYM - 1));

    // ---------------- output FIFO control ----------------
    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;
    assign pop        = out_valid & out_ready;
    // A pop in the same cycle frees the slot the new packet needs.
    assign push       = complete & ((count != CW'(DEPTH)) | pop);
    assign drop       = complete & ~push;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pulse_q  <= 1'b0;
            t        <= '0;
            seen     <= 1'b0;
            pre_cnt  <= '0;
            sym_cnt  <= '0;
            sym      <= '0;
            asm_r    <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
            overflow <= 1'b0;
        end else begin
            pulse_q  <= pulse;
            err      <= 1'b0;
            overflow <= drop;
            if (any_err) begin
                // Abort: the partial packet is dropped and any edge now is ignored.
                err      <= 1'b1;
                err_code <= code;
                state    <= IDLE;
                t        <= '0;
                seen     <= 1'b0;
                sym_cnt  <= '0;
                asm_r    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (edge_det) begin
                            // The edge cycle is tick 0 of the first frame.
                            state   <= PREAM;
                            t       <= TW'(1);
                            seen    <= 1'b1;
                            pre_cnt <= PCW'(1);
                        end
                    end
                    PREAM: begin
                        if (edge_det) begin
                            // Slot-0 edge with no prior edge: realign the timer.
                            t    <= TW'(1);
                            seen <= 1'b1;
                        end else if (t_last) begin
                            t    <= '0;
                            seen <= 1'b0;
                            if (pre_cnt == PCW'(PRE_CT)) begin
                                state   <= DATA;
                                sym_cnt <= '0;
                                asm_r   <= '0;
                            end else begin
                                pre_cnt <= pre_cnt + 1'b1;
                            end
                        end else begin
                            t <= t + 1'b1;
                        end
                    end
                    DATA: begin
                        t <= t_last ? '0 : t + 1'b1;
                        if (edge_det) begin
                            sym  <= slot;
                            seen <= 1'b1;
                        end
                        if (t_last) begin
                            seen    <= 1'b0;
                            asm_r   <= asm_next;
                            sym_cnt <= sym_cnt + 1'b1;
                            if (complete) begin
                                state   <= IDLE;
                                t       <= '0;
                                sym_cnt <= '0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= asm_next[N_PKT-1:0];
        end
    end

endmodule
